mrnaiso_ctl_sequencer: RTL and testbench

- Digital controller driving the pneumatic control lines of the 4-stage mRNA isolation chip.
- Converts a host start/abort handshake into timed valve and pump patterns for cell load, lysis, bead mix, separation, collect and flush.
- Sits off-chip, in the pressure-manifold FPGA, and drives one solenoid per control line.
- Valve convention: control line 1 = pressurised = valve closed; 0 = open.

---
 rtl/mrnaiso_ctl_pkg.sv | 88 ++++++++
 rtl/mrnaiso_ctl_sequencer_if.sv | 52 +++++
 rtl/mrnaiso_ctl_sequencer_pump.sv | 49 ++++
 rtl/mrnaiso_ctl_sequencer.sv | 161 ++++++++++++++++
 tb/tb_mrnaiso_ctl_sequencer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mrnaiso_ctl_pkg.sv
// Shared types and constants for the mRNA isolation chip valve/pump sequencer.
// Holds the state enum, valve polarity, pump phase table and valve pattern decode.
package mrnaiso_ctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LYSE,
    ST_BEAD,
    ST_SEP,
    ST_COLLECT,
    ST_DONE,
    ST_FLUSH
  } state_e;

  // Pressurised control line closes the valve.
  localparam logic VALVE_CLOSED = 1'b1;
  localparam logic VALVE_OPEN   = 1'b0;

  localparam logic [2:0] PUMP_IDLE   = 3'b111;
  localparam int         PUMP_PHASES = 6;
  localparam logic [2:0] PUMP_TABLE [PUMP_PHASES] = '{
    3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001
  };

  typedef struct packed {
    logic [3:0] cells_in;
    logic [3:0] collect;
    logic       lysis_in;
    logic       lysis_waste;
    logic       beads_12;
    logic       beads_34;
    logic       bead_waste;
    logic       sieve_12;
    logic       sieve_34;
    logic       sep;
    logic       push;
    logic       waste;
  } valves_t;

  localparam valves_t VALVES_CLOSED = '1;

  function automatic int max_int(int a, int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic pumping(state_e s);
    return (s == ST_LYSE) || (s == ST_BEAD) || (s == ST_FLUSH);
  endfunction

  // Valve pattern for a state given the latched stage mask.
  function automatic valves_t valves_for(state_e s, logic [3:0] m);
    valves_t v;
    v = VALVES_CLOSED;
    case (s)
      ST_LOAD: begin
        v.cells_in = ~m;
        v.waste    = VALVE_OPEN;
      end
      ST_LYSE: begin
        v.lysis_in    = VALVE_OPEN;
        v.lysis_waste = VALVE_OPEN;
      end
      ST_BEAD: begin
        if (|m[1:0]) v.beads_12 = VALVE_OPEN;
        if (|m[3:2]) v.beads_34 = VALVE_OPEN;
      end
      ST_SEP: begin
        v.sep        = VALVE_OPEN;
        v.bead_waste = VALVE_OPEN;
        if (|m[1:0]) v.sieve_12 = VALVE_OPEN;
        if (|m[3:2]) v.sieve_34 = VALVE_OPEN;
      end
      ST_COLLECT: begin
        v.collect = ~m;
        v.push    = VALVE_OPEN;
      end
      ST_FLUSH: begin
        v.waste       = VALVE_OPEN;
        v.lysis_waste = VALVE_OPEN;
        v.bead_waste  = VALVE_OPEN;
      end
      default: v = VALVES_CLOSED;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mrnaiso_ctl_sequencer_if.sv
// Host/manifold bundle: start/abort request side plus all solenoid drives.
// master = host/testbench, slave = sequencer.
interface mrnaiso_ctl_sequencer_if;

  logic       start;
  logic [3:0] stage_mask;
  logic       abort;

  logic       busy;
  logic       done;
  logic       aborted;
  logic       err;

  logic [3:0] cells_in_ctl;
  logic [3:0] collect_ctl;
  logic       lysis_in_ctl;
  logic       lysis_waste_ctl;
  logic       beads_in_ctl_1_2;
  logic       beads_in_ctl_3_4;
  logic       bead_waste_ctl;
  logic       sieve_ctl_1_2;
  logic       sieve_ctl_3_4;
  logic       sep_ctl;
  logic       push_ctl;
  logic       waste_ctl;
  logic [2:0] pump;

  modport master (
    output start, stage_mask, abort,
    input  busy, done, aborted, err,
    input  cells_in_ctl, collect_ctl,
    input  lysis_in_ctl, lysis_waste_ctl,
    input  beads_in_ctl_1_2, beads_in_ctl_3_4,
    input  bead_waste_ctl,
    input  sieve_ctl_1_2, sieve_ctl_3_4,
    input  sep_ctl, push_ctl, waste_ctl,
    input  pump
  );

  modport slave (
    input  start, stage_mask, abort,
    output busy, done, aborted, err,
    output cells_in_ctl, collect_ctl,
    output lysis_in_ctl, lysis_waste_ctl,
    output beads_in_ctl_1_2, beads_in_ctl_3_4,
    output bead_waste_ctl,
    output sieve_ctl_1_2, sieve_ctl_3_4,
    output sep_ctl, push_ctl, waste_ctl,
    output pump
  );

endinterface

// File: rtl/mrnaiso_ctl_sequencer_pump.sv
// Peristaltic pump driver: PUMP_DIV prescaler stepping a six-phase pattern.
// Ports: clk, rst, en_i (pump runs), restart_i (phase 0 next cycle), pat_o (registered).
module peristaltic_pump_drv
  import mrnaiso_ctl_pkg::*;
#(
  parameter int PUMP_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       restart_i,
  output logic [2:0] pat_o
);

  localparam int DW = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PUMP_DIV - 1);
  localparam logic [2:0] PH_LAST = 3'(PUMP_PHASES - 1);

  logic [DW-1:0] div_q;
  logic [2:0]    ph_q;
  logic [2:0]    ph_nxt;
  logic [2:0]    pat_q;

  assign ph_nxt = (ph_q == PH_LAST) ? 3'd0 : ph_q + 3'd1;
  assign pat_o  = pat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      ph_q  <= '0;
      pat_q <= PUMP_IDLE;
    end else if (!en_i) begin
      div_q <= '0;
      ph_q  <= '0;
      pat_q <= PUMP_IDLE;
    end else if (restart_i) begin
      div_q <= '0;
      ph_q  <= '0;
      pat_q <= PUMP_TABLE[0];
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
      ph_q  <= ph_nxt;
      pat_q <= PUMP_TABLE[ph_nxt];
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

endmodule

// File: rtl/mrnaiso_ctl_sequencer.sv
// Sequencer turning host start/abort into timed valve/pump patterns for the chip.
// Ports: clk, rst (async, active-high), ctl (slave side of the handshake/valve bundle).
module mrnaiso_ctl_sequencer
  import mrnaiso_ctl_pkg::*;
#(
  parameter int T_LOAD   = 16,
  parameter int T_LYSE   = 32,
  parameter int T_BEAD   = 32,
  parameter int T_SEP    = 16,
  parameter int T_COLL   = 16,
  parameter int T_FLUSH  = 8,
  parameter int PUMP_DIV = 4
) (
  input logic                    clk,
  input logic                    rst,
  mrnaiso_ctl_sequencer_if.slave ctl
);

  localparam int T_MAX = max_int(max_int(max_int(T_LOAD, T_LYSE),
                                         max_int(T_BEAD, T_SEP)),
                                 max_int(T_COLL, T_FLUSH));
  localparam int CNT_W = max_int($clog2(T_MAX), 1);

  typedef logic [CNT_W-1:0] cnt_t;

  state_e     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [3:0] mask_q, mask_d;
  valves_t    vlv_q, vlv_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       aborted_q, aborted_d;
  logic       err_q, err_d;
  logic       cnt_zero;
  logic       pump_en;
  logic       pump_restart;
  logic [2:0] pump_pat;

  function automatic cnt_t dwell(state_e s);
    case (s)
      ST_LOAD:    return cnt_t'(T_LOAD - 1);
      ST_LYSE:    return cnt_t'(T_LYSE - 1);
      ST_BEAD:    return cnt_t'(T_BEAD - 1);
      ST_SEP:     return cnt_t'(T_SEP - 1);
      ST_COLLECT: return cnt_t'(T_COLL - 1);
      ST_FLUSH:   return cnt_t'(T_FLUSH - 1);
      default:    return '0;
    endcase
  endfunction

  function automatic state_e next_timed(state_e s);
    case (s)
      ST_LOAD:    return ST_LYSE;
      ST_LYSE:    return ST_BEAD;
      ST_BEAD:    return ST_SEP;
      ST_SEP:     return ST_COLLECT;
      ST_COLLECT: return ST_DONE;
      default:    return ST_IDLE;
    endcase
  endfunction

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    aborted_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ctl.start) begin
          if (ctl.stage_mask == 4'd0) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
            mask_d  = ctl.stage_mask;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_FLUSH: begin
        if (cnt_zero) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end
      end
      default: begin
        // Abort wins over a timed exit on the same cycle.
        if (ctl.abort) begin
          state_d = ST_FLUSH;
        end else if (cnt_zero) begin
          state_d = next_timed(state_q);
        end
      end
    endcase
    if (state_d != state_q) begin
      cnt_d = dwell(state_d);
    end else if (!cnt_zero) begin
      cnt_d = cnt_q - cnt_t'(1);
    end
    // Outputs are decoded from the next state so they land with it.
    vlv_d  = valves_for(state_d, mask_d);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  assign pump_en      = pumping(state_d);
  assign pump_restart = pump_en && (state_d != state_q);

  peristaltic_pump_drv #(
    .PUMP_DIV (PUMP_DIV)
  ) u_pump (
    .clk       (clk),
    .rst       (rst),
    .en_i      (pump_en),
    .restart_i (pump_restart),
    .pat_o     (pump_pat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mask_q    <= '0;
      vlv_q     <= VALVES_CLOSED;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      vlv_q     <= vlv_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      err_q     <= err_d;
    end
  end

  assign ctl.busy             = busy_q;
  assign ctl.done             = done_q;
  assign ctl.aborted          = aborted_q;
  assign ctl.err              = err_q;
  assign ctl.cells_in_ctl     = vlv_q.cells_in;
  assign ctl.collect_ctl      = vlv_q.collect;
  assign ctl.lysis_in_ctl     = vlv_q.lysis_in;
  assign ctl.lysis_waste_ctl  = vlv_q.lysis_waste;
  assign ctl.beads_in_ctl_1_2 = vlv_q.beads_12;
  assign ctl.beads_in_ctl_3_4 = vlv_q.beads_34;
  assign ctl.bead_waste_ctl   = vlv_q.bead_waste;
  assign ctl.sieve_ctl_1_2    = vlv_q.sieve_12;
  assign ctl.sieve_ctl_3_4    = vlv_q.sieve_34;
  assign ctl.sep_ctl          = vlv_q.sep;
  assign ctl.push_ctl         = vlv_q.push;
  assign ctl.waste_ctl        = vlv_q.waste;
  assign ctl.pump             = pump_pat;

endmodule

// File: tb/tb_mrnaiso_ctl_sequencer.sv
// Scoreboard bench for the mRNA isolation sequencer.
// Expected per-cycle output vectors are queued at stimulus time and popped each cycle.
module tb_mrnaiso_ctl_sequencer;

  localparam int T_LOAD   = 16;
  localparam int T_LYSE   = 32;
  localparam int T_BEAD   = 32;
  localparam int T_SEP    = 16;
  localparam int T_COLL   = 16;
  localparam int T_FLUSH  = 8;
  localparam int PUMP_DIV = 4;

  localparam int S_IDLE = 0;
  localparam int S_LOAD = 1;
  localparam int S_LYSE = 2;
  localparam int S_BEAD = 3;
  localparam int S_SEP  = 4;
  localparam int S_COLL = 5;
  localparam int S_DONE = 6;
  localparam int S_FLSH = 7;

  typedef struct {
    string       tag;
    logic [24:0] v;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;
  int   done_cnt;
  int   done_cyc;
  int   cyc0;
  exp_t exp_q[$];
  logic [2:0] pt [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

  mrnaiso_ctl_sequencer_if bus ();

  mrnaiso_ctl_sequencer #(
    .T_LOAD   (T_LOAD),
    .T_LYSE   (T_LYSE),
    .T_BEAD   (T_BEAD),
    .T_SEP    (T_SEP),
    .T_COLL   (T_COLL),
    .T_FLUSH  (T_FLUSH),
    .PUMP_DIV (PUMP_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ctl (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: {busy,done,aborted,err,cells,collect,10 valves,pump}.
  function automatic logic [24:0] model(int st, logic [3:0] m, logic [2:0] p,
                                        logic d, logic a, logic e);
    logic [3:0] ci, co;
    logic li, lw, b12, b34, bw, s12, s34, sp, pu, wa;
    ci = 4'hF; co = 4'hF;
    {li, lw, b12, b34, bw, s12, s34, sp, pu, wa} = 10'h3FF;
    case (st)
      S_LOAD: begin ci = ~m; wa = 1'b0; end
      S_LYSE: begin li = 1'b0; lw = 1'b0; end
      S_BEAD: begin
        b12 = !(m[0] || m[1]);
        b34 = !(m[2] || m[3]);
      end
      S_SEP: begin
        sp = 1'b0; bw = 1'b0;
        s12 = (m[1:0] == 2'b00);
        s34 = (m[3:2] == 2'b00);
      end
      S_COLL: begin co = ~m; pu = 1'b0; end
      S_FLSH: begin wa = 1'b0; lw = 1'b0; bw = 1'b0; end
      default: ;
    endcase
    return {st != S_IDLE, d, a, e, ci, co,
            li, lw, b12, b34, bw, s12, s34, sp, pu, wa, p};
  endfunction

  function automatic logic [24:0] dut_vec();
    return {bus.busy, bus.done, bus.aborted, bus.err,
            bus.cells_in_ctl, bus.collect_ctl,
            bus.lysis_in_ctl, bus.lysis_waste_ctl,
            bus.beads_in_ctl_1_2, bus.beads_in_ctl_3_4,
            bus.bead_waste_ctl, bus.sieve_ctl_1_2, bus.sieve_ctl_3_4,
            bus.sep_ctl, bus.push_ctl, bus.waste_ctl, bus.pump};
  endfunction

  task automatic push_one(string nm, int st, logic [3:0] m,
                          logic d, logic a, logic e);
    exp_t x;
    x.tag = nm;
    x.v   = model(st, m, 3'b111, d, a, e);
    exp_q.push_back(x);
  endtask

  task automatic push_seg(string nm, int st, int len, logic [3:0] m, bit pmp);
    exp_t x;
    for (int k = 0; k < len; k++) begin
      x.tag = $sformatf("%s[%0d]", nm, k);
      x.v   = model(st, m, pmp ? pt[(k / PUMP_DIV) % 6] : 3'b111,
                    1'b0, 1'b0, 1'b0);
      exp_q.push_back(x);
    end
  endtask

  task automatic push_full(logic [3:0] m);
    push_seg("LOAD", S_LOAD, T_LOAD, m, 1'b0);
    push_seg("LYSE", S_LYSE, T_LYSE, m, 1'b1);
    push_seg("BEAD", S_BEAD, T_BEAD, m, 1'b1);
    push_seg("SEP",  S_SEP,  T_SEP,  m, 1'b0);
    push_seg("COLL", S_COLL, T_COLL, m, 1'b0);
    push_one("DONE", S_DONE, m, 1'b1, 1'b0, 1'b0);
    push_one("IDLE_AFTER_DONE", S_IDLE, m, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    exp_t x;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: observed %07h expected none queued", dut_vec());
    end
    if (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      assert (dut_vec() === x.v) else begin
        errors++;
        $error("FAIL %s: observed %07h expected %07h", x.tag, dut_vec(), x.v);
      end
    end
  endtask

  task automatic check_vec(string nm, logic [24:0] e);
    checks++;
    assert (dut_vec() === e) else begin
      errors++;
      $error("FAIL %s: observed %07h expected %07h", nm, dut_vec(), e);
    end
  endtask

  task automatic check_int(string nm, int o, int e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", nm, o, e);
    end
  endtask

  initial begin
    logic [24:0] rst_vec;
    checks = 0; errors = 0; cyc = 0;
    done_cnt = 0; done_cyc = 0; cyc0 = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.stage_mask = 4'h0;
    rst_vec = model(S_IDLE, 4'h0, 3'b111, 1'b0, 1'b0, 1'b0);
    #12;
    check_vec("reset_state", rst_vec);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Run A: mask 0101, whole run traced.
    push_full(4'b0101);
    bus.start = 1'b1; bus.stage_mask = 4'b0101;
    tick();
    repeat (T_LOAD + T_LYSE + T_BEAD + T_SEP + T_COLL + 1) tick();

    // Run B: mask 0001, also measure done latency from start accept.
    push_full(4'b0001);
    done_cnt = 0;
    cyc0 = cyc;
    bus.start = 1'b1; bus.stage_mask = 4'b0001;
    tick();
    repeat (T_LOAD + T_LYSE + T_BEAD + T_SEP + T_COLL + 1) tick();
    check_int("done_count_B", done_cnt, 1);
    check_int("done_latency_B", done_cyc - cyc0,
              T_LOAD + T_LYSE + T_BEAD + T_SEP + T_COLL + 1);

    // Zero mask start: err pulse, stays idle.
    push_one("ERR_PULSE", S_IDLE, 4'h0, 1'b0, 1'b0, 1'b1);
    push_one("ERR_CLEAR", S_IDLE, 4'h0, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1; bus.stage_mask = 4'b0000;
    tick();
    tick();

    // Abort on the last LYSE cycle: FLUSH, then aborted pulse, no done.
    push_seg("LOAD_AB", S_LOAD, T_LOAD, 4'b0011, 1'b0);
    push_seg("LYSE_AB", S_LYSE, T_LYSE, 4'b0011, 1'b1);
    push_seg("FLUSH", S_FLSH, T_FLUSH, 4'b0011, 1'b1);
    push_one("ABORTED_PULSE", S_IDLE, 4'b0011, 1'b0, 1'b1, 1'b0);
    push_one("IDLE_AFTER_ABORT", S_IDLE, 4'b0011, 1'b0, 1'b0, 1'b0);
    done_cnt = 0;
    bus.start = 1'b1; bus.stage_mask = 4'b0011;
    tick();
    repeat (T_LOAD + T_LYSE - 1) tick();
    bus.abort = 1'b1;
    repeat (T_FLUSH + 2) tick();
    check_int("done_count_abort", done_cnt, 0);

    // Reset mid-SEP, then a normal run afterwards.
    push_full(4'b0110);
    bus.start = 1'b1; bus.stage_mask = 4'b0110;
    tick();
    repeat (T_LOAD + T_LYSE + T_BEAD + 5) tick();
    rst = 1'b1;
    #2;
    check_vec("async_reset_midsep", rst_vec);
    exp_q.delete();
    @(posedge clk);
    #1;
    check_vec("held_reset", rst_vec);
    rst = 1'b0;
    push_full(4'b1001);
    bus.start = 1'b1; bus.stage_mask = 4'b1001;
    tick();
    repeat (T_LOAD + T_LYSE + T_BEAD + T_SEP + T_COLL + 1) tick();

    // Start with a new mask during BEAD must be ignored.
    push_full(4'b0010);
    done_cnt = 0;
    cyc0 = cyc;
    bus.start = 1'b1; bus.stage_mask = 4'b0010;
    tick();
    repeat (T_LOAD + T_LYSE + 12) tick();
    bus.start = 1'b1; bus.stage_mask = 4'b1111;
    repeat (T_BEAD - 12 + T_SEP + T_COLL + 1) tick();
    check_int("done_count_restart", done_cnt, 1);
    check_int("done_latency_restart", done_cyc - cyc0,
              T_LOAD + T_LYSE + T_BEAD + T_SEP + T_COLL + 1);

    check_int("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
